// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-state, judgement and combo definitions
package game_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SONG_SELECT = 2'd1,
        GAME_PLAY   = 2'd2,
        GAME_OVER   = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        JUDGE_MISS    = 2'b00,
        JUDGE_EARLY   = 2'b01,
        JUDGE_LATE    = 2'b10,
        JUDGE_PERFECT = 2'b11
    } judge_e;

    localparam logic [7:0] COMBO_MAX = 8'd255;

    function automatic logic [7:0] combo_inc(input logic [7:0] c);
        return (c == COMBO_MAX) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/hit_judge_if.sv
// rtl/hit_judge_if.sv - judgement bus from hit_judge to the score counter
interface hit_judge_if;
    import game_pkg::*;

    logic       judge_valid;
    judge_e     Inp;
    logic [7:0] combo;
    logic [7:0] max_combo;

    modport master (output judge_valid, Inp, combo, max_combo);
    modport slave  (input  judge_valid, Inp, combo, max_combo);
endinterface

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - 2-flop synchronizer plus registered rising-edge pulse
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    // sync_q[1:0] is the synchronizer, sync_q[2] the previous synchronized level
    logic [2:0] sync_q;
    logic       press_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], btn_i};
            press_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign press_o = press_q;
endmodule

// File: rtl/hit_judge.sv
// rtl/hit_judge.sv - judges button presses against note windows, tracks combo
// Optional: GHOST_PENALTY_EN makes a press with no armed note count as a miss.
module hit_judge
    import game_pkg::*;
#(
    parameter int GOOD_WIN    = 40,
    parameter int PERFECT_WIN = 10,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   game_state,
    input  logic         tick_en,
    input  logic         note_in,
    input  logic         btn,
    hit_judge_if.master  judge_if
);
    localparam int P     = 2 * PERFECT_WIN + 1;
    localparam int LIMIT = 2 * GOOD_WIN + P;

    localparam logic [CNT_W-1:0] EARLY_END = CNT_W'(GOOD_WIN);
    localparam logic [CNT_W-1:0] PERF_END  = CNT_W'(GOOD_WIN + P);
    localparam logic [CNT_W-1:0] T_LIMIT   = CNT_W'(LIMIT);

    typedef enum logic {ST_IDLE, ST_ARMED} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic             valid_q, valid_d;
    judge_e           inp_q, inp_d;
    logic [7:0]       combo_q, combo_d;
    logic [7:0]       max_q, max_d;

    logic   press;
    logic   playing;
    logic   judge;
    judge_e verdict;

    btn_sync_edge u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn),
        .press_o (press)
    );

    assign playing = (game_state == GAME_PLAY);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        valid_d = 1'b0;
        inp_d   = inp_q;
        combo_d = combo_q;
        max_d   = max_q;
        judge   = 1'b0;
        verdict = JUDGE_MISS;

        case (state_q)
            ST_IDLE: begin
                if (playing && note_in) begin
                    state_d = ST_ARMED;
                    t_d     = '0;
                end
`ifdef GHOST_PENALTY_EN
                else if (playing && press) begin
                    judge   = 1'b1;
                    verdict = JUDGE_MISS;
                end
`endif
            end
            ST_ARMED: begin
                if (!playing) begin
                    state_d = ST_IDLE;
                    t_d     = '0;
                end else begin
                    // A press beats both timeout and a new note for the pending note
                    if (press) begin
                        judge = 1'b1;
                        if (t_q < EARLY_END)     verdict = JUDGE_EARLY;
                        else if (t_q < PERF_END) verdict = JUDGE_PERFECT;
                        else                     verdict = JUDGE_LATE;
                    end else if (note_in || (t_q == T_LIMIT)) begin
                        judge   = 1'b1;
                        verdict = JUDGE_MISS;
                    end

                    if (note_in) begin
                        t_d = '0;
                    end else if (judge) begin
                        state_d = ST_IDLE;
                        t_d     = '0;
                    end else if (tick_en) begin
                        t_d = t_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
        endcase

        if (judge) begin
            valid_d = 1'b1;
            inp_d   = verdict;
            combo_d = (verdict == JUDGE_MISS) ? 8'd0 : combo_inc(combo_q);
            if (combo_d > max_q) max_d = combo_d;
        end

        if (game_state == GAME_OVER || game_state == SONG_SELECT) begin
            combo_d = 8'd0;
            max_d   = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            valid_q <= 1'b0;
            inp_q   <= JUDGE_MISS;
            combo_q <= 8'd0;
            max_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            valid_q <= valid_d;
            inp_q   <= inp_d;
            combo_q <= combo_d;
            max_q   <= max_d;
        end
    end

    assign judge_if.judge_valid = valid_q;
    assign judge_if.Inp         = inp_q;
    assign judge_if.combo       = combo_q;
    assign judge_if.max_combo   = max_q;
endmodule
